data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-through, no-write-allocate data cache sitting directly downstream of the ALU. It takes the ALU `result` as a byte address and serves load/store requests from the Decoder & Control memory flags. Misses and all stores go to a word-wide backing-memory port with a req/ack handshake. While a request cannot complete in the current cycle, `stall` holds the pipeline.

## Interface
Parameters:
- `INDEX_BITS`, 4: line index width (16 lines).
- `DATA_WIDTH`, 32: word width. Fixed at 32 for this revision.

Ports:
- `clock`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `address`, in, 32: byte address (ALU `result`).
  - [1:0] byte offset, ignored.
  - [3:2] word in line.
  - [3+INDEX_BITS:4] index.
  - Remaining upper bits are the tag.
- `writeData`, in, 32: store data.
- `memReadFlag`, in, 1: load request.
- `memWriteFlag`, in, 1: store request.
- `readData`, out, 32: load data. Combinational; valid when `memReadFlag` is 1 and `stall` is 0, otherwise 0.
- `stall`, out, 1: combinational. 1 means the request is not complete and the requester must hold `address`, `writeData` and the flags stable.
- `memReq`, out, 1: backing-memory request. Registered.
- `memWe`, out, 1: 1 = write beat, 0 = read beat. Registered.
- `memAddr`, out, 32: word-aligned backing address. Registered, [1:0] always 0.
- `memWData`, out, 32: backing write data. Registered.
- `memRData`, in, 32: backing read data. Sampled only when `memAck` is 1.
- `memAck`, in, 1: one beat accepted/returned. Sampled on the clock edge.

## Operation
- Storage per line:
  - valid bit;
  - tag;
  - 4 data words.
- A hit requires the line's valid bit set and a tag match.
- FSM states: IDLE, FILL, WRITE, WDONE.
- IDLE behaviour:
  - Read with hit: `stall`=0 and `readData` = selected word. No state change.
  - Read with miss: `stall`=1. Next state FILL; `memAddr` ← line base (address with [3:0]=0); beat counter ← 0; `memReq`←1, `memWe`←0.
  - Write (hit or miss): `stall`=1. Next state WRITE; `memAddr` ← address with [1:0]=0; `memWData` ← `writeData`; `memReq`←1, `memWe`←1.
  - Both flags high: the write wins and the read is ignored.
  - No flag: `stall`=0. `memAck` is ignored.
- FILL behaviour:
  - `stall`=1.
  - On each edge with `memAck`=1: word[counter] ← `memRData`; counter increments; `memAddr` advances by 4.
  - On the 4th ack:
    - set valid, write tag, clear `memReq`, go to IDLE;
    - the held read then hits.
- WRITE behaviour:
  - `stall`=1.
  - On the ack edge: if the line hits, update the cached word with `writeData` (no-write-allocate: a miss leaves the cache unchanged); clear `memReq`/`memWe`; go to WDONE.
- WDONE behaviour:
  - `stall`=0, so the store retires this cycle.
  - Unconditionally go to IDLE.
- A line being filled is never marked valid before all 4 beats have landed.
- Reset, including reset during FILL or WRITE:
  - state IDLE;
  - all valid bits 0;
  - `memReq`, `memWe` = 0;
  - `memAddr`, `memWData` = 0;
  - beat counter 0;
  - partial fill data discarded.
  - Data/tag arrays need no reset.

## Timing
- Read hit: 0 stall cycles, data in the same cycle.
- Read miss, zero-wait memory (ack in the same cycle as `memReq`):
  - cycle 0: miss detected;
  - cycles 1–4: beats;
  - cycle 5: hit with `stall`=0.
  - Total: 5 stall cycles. Each memory wait state adds 1.
- Store, zero-wait memory:
  - cycle 0: IDLE;
  - cycle 1: WRITE with ack;
  - cycle 2: WDONE, `stall`=0.
  - Total: 2 stall cycles.
- `memReq` stays high continuously across all 4 fill beats. It falls on the edge of the final ack.
- `memAck` while `memReq`=0 is ignored.

## Test plan
- Reset, then read 0x100 with memory word n = 0xA000_0000+n:
  - `stall` high for 5 cycles;
  - 4 read beats at 0x100, 0x104, 0x108, 0x10C;
  - then `readData`=0xA000_0040, `stall`=0.
- Read 0x108 immediately after the fill:
  - 0 stall cycles, `readData`=0xA000_0042;
  - no `memReq`.
- Store 0xDEADBEEF to 0x104 (hit):
  - 1 write beat with `memAddr`=0x104, `memWe`=1;
  - `stall` drops in WDONE;
  - a later read of 0x104 returns 0xDEADBEEF without a fill.
- Store to 0x2000 (miss):
  - write beat issued;
  - a subsequent read of 0x2000 misses and fills. No allocate on write.
- Conflict and address handling:
  - Read 0x100, then read 0x1100 (same index 0, different tag): second fill evicts the first line, and re-reading 0x100 misses again.
  - 0x102 reads the same word as 0x100.
- Robustness:
  - Reset asserted after 2 of 4 fill beats: `memReq` is 0 the next cycle, and a later read of the same line performs a full 4-beat fill.
  - Both flags high: treated as a store.
  - Ack with 3 wait cycles per beat: 17 stall cycles.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Misses fill a whole line over a req/ack word port. Every store is also written through that port.
module data_cache #(
  parameter int INDEX_BITS = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  memReadFlag,
  input  logic                  memWriteFlag,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  stall,
  output logic                  memReq,
  output logic                  memWe,
  output logic [31:0]           memAddr,
  output logic [DATA_WIDTH-1:0] memWData,
  input  logic [DATA_WIDTH-1:0] memRData,
  input  logic                  memAck
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] WDONE = 2'd3;

  logic [1:0]            state;
  logic [1:0]            beatCount;
  logic [LINES-1:0]      validBits;
  logic [TAG_BITS-1:0]   tagArray  [LINES];
  logic [DATA_WIDTH-1:0] dataArray [LINES][4];

  logic [INDEX_BITS-1:0] lineIndex;
  logic [1:0]            wordSel;
  logic [TAG_BITS-1:0]   addrTag;
  logic                  hit;
  logic                  unusedByteOffset;

  assign wordSel          = address[3:2];
  assign lineIndex        = address[3+INDEX_BITS:4];
  assign addrTag          = address[31:4+INDEX_BITS];
  assign unusedByteOffset = ^address[1:0];
  assign hit              = validBits[lineIndex] && (tagArray[lineIndex] == addrTag);

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:        stall = memWriteFlag || (memReadFlag && !hit);
      FILL, WRITE: stall = 1'b1;
      default:     stall = 1'b0;
    endcase
  end

  assign readData = (memReadFlag && !stall) ? dataArray[lineIndex][wordSel] : '0;

  // The requester holds the address stable, so index and tag come straight from it in every state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      beatCount <= 2'd0;
      validBits <= '0;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memWriteFlag) begin
            state    <= WRITE;
            memAddr  <= {address[31:2], 2'b00};
            memWData <= writeData;
            memReq   <= 1'b1;
            memWe    <= 1'b1;
          end else if (memReadFlag && !hit) begin
            state                <= FILL;
            memAddr              <= {address[31:4], 4'b0000};
            beatCount            <= 2'd0;
            memReq               <= 1'b1;
            memWe                <= 1'b0;
            validBits[lineIndex] <= 1'b0;
          end
        end
        FILL: begin
          if (memAck) begin
            beatCount <= beatCount + 2'd1;
            memAddr   <= memAddr + 32'd4;
            if (beatCount == 2'd3) begin
              validBits[lineIndex] <= 1'b1;
              memReq               <= 1'b0;
              state                <= IDLE;
            end
          end
        end
        WRITE: begin
          if (memAck) begin
            memReq <= 1'b0;
            memWe  <= 1'b0;
            state  <= WDONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; a line becomes usable only through its valid bit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == FILL && memAck) begin
        dataArray[lineIndex][beatCount] <= memRData;
        if (beatCount == 2'd3) begin
          tagArray[lineIndex] <= addrTag;
        end
      end
      if (state == WRITE && memAck && hit) begin
        dataArray[lineIndex][wordSel] <= writeData;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache: a word-addressed memory model plus a line-residency model
// predict read data, stall lengths and the exact beats seen on the memory port.
module tb_data_cache;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic        memReadFlag = 1'b0;
  logic        memWriteFlag = 1'b0;
  logic [31:0] readData;
  logic        stall;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] memRData = '0;
  logic        memAck = 1'b0;

  int errors = 0;
  int checks = 0;
  int waitStates = 0;
  int waitCnt = 0;

  logic [31:0] backMem [int];
  logic [31:0] refMem [int];
  bit          residentValid [16];
  int          residentTag [16];

  bit          beatWe [$];
  logic [31:0] beatAddr [$];
  logic [31:0] beatData [$];

  data_cache #(.INDEX_BITS(4), .DATA_WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .address(address),
    .writeData(writeData),
    .memReadFlag(memReadFlag),
    .memWriteFlag(memWriteFlag),
    .readData(readData),
    .stall(stall),
    .memReq(memReq),
    .memWe(memWe),
    .memAddr(memAddr),
    .memWData(memWData),
    .memRData(memRData),
    .memAck(memAck)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] wordAt(input logic [31:0] a, input bit useRef);
    int key;
    key = int'(a >> 2);
    if (useRef) return refMem.exists(key) ? refMem[key] : 32'hA000_0000 + (a >> 2);
    return backMem.exists(key) ? backMem[key] : 32'hA000_0000 + (a >> 2);
  endfunction

  // Backing memory: waitStates idle cycles before each ack, random noise on memAck while idle.
  always @(negedge clock) begin
    if (memReq && !reset) begin
      if (waitCnt >= waitStates) begin
        memAck   = 1'b1;
        memRData = wordAt(memAddr, 1'b0);
        waitCnt  = 0;
      end else begin
        memAck  = 1'b0;
        waitCnt = waitCnt + 1;
      end
    end else begin
      memAck  = 1'($urandom_range(0, 1));
      waitCnt = 0;
    end
  end

  always @(posedge clock) begin
    if (!reset && memReq && memAck) begin
      beatWe.push_back(memWe);
      beatAddr.push_back(memAddr);
      beatData.push_back(memWData);
      if (memWe) backMem[int'(memAddr >> 2)] = memWData;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    int line, idx, ltag, stallCycles, expStall, expBeats, n;
    bit expHit;
    line = int'(addr >> 4);
    idx  = line % 16;
    ltag = line / 16;
    expHit = residentValid[idx] && residentTag[idx] == ltag;
    if (wr) begin
      expStall = 2 + waitStates;
      expBeats = 1;
    end else if (rd && !expHit) begin
      expStall = 1 + 4 * (waitStates + 1);
      expBeats = 4;
    end else begin
      expStall = 0;
      expBeats = 0;
    end
    @(posedge clock);
    #1;
    address = addr;
    writeData = wdata;
    memReadFlag = rd;
    memWriteFlag = wr;
    beatWe.delete();
    beatAddr.delete();
    beatData.delete();
    stallCycles = 0;
    @(negedge clock);
    while (stall !== 1'b0 && stallCycles < 200) begin
      stallCycles++;
      @(negedge clock);
    end
    checkOutput("stallCycles", stallCycles, expStall);
    checkOutput("beatCount", beatAddr.size(), expBeats);
    checkOutput("memReqIdle", memReq, 1'b0);
    n = (beatAddr.size() < expBeats) ? beatAddr.size() : expBeats;
    for (int i = 0; i < n; i++) begin
      if (wr) begin
        checkOutput("writeBeatWe", beatWe[i], 1'b1);
        checkOutput("writeBeatAddr", beatAddr[i], {addr[31:2], 2'b00});
        checkOutput("writeBeatData", beatData[i], wdata);
      end else begin
        checkOutput("fillBeatWe", beatWe[i], 1'b0);
        checkOutput("fillBeatAddr", beatAddr[i], 32'(line * 16 + i * 4));
      end
    end
    if (rd && !wr) checkOutput("readData", readData, wordAt(addr, 1'b1));
    if (!rd && !wr) checkOutput("readDataIdle", readData, 32'h0);
    if (wr) begin
      refMem[int'(addr >> 2)] = wdata;
    end else if (rd && !expHit) begin
      residentValid[idx] = 1'b1;
      residentTag[idx] = ltag;
    end
    @(posedge clock);
    #1;
    memReadFlag = 1'b0;
    memWriteFlag = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int tags [4];
    int n, kind;
    logic [31:0] a;
    tags = '{0, 1, 32'h20, 32'hFF};

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("resetMemReq", memReq, 1'b0);
    checkOutput("resetMemWe", memWe, 1'b0);
    checkOutput("resetMemAddr", memAddr, 32'h0);
    checkOutput("resetMemWData", memWData, 32'h0);
    checkOutput("resetStall", stall, 1'b0);
    checkOutput("resetReadData", readData, 32'h0);
    reset = 1'b0;

    waitStates = 0;
    applyStimulus(1, 0, 32'h100, 0);
    checkOutput("firstFillData", readData, 32'hA000_0040);
    applyStimulus(1, 0, 32'h108, 0);
    applyStimulus(0, 1, 32'h104, 32'hDEADBEEF);
    applyStimulus(1, 0, 32'h104, 0);
    applyStimulus(0, 1, 32'h2000, 32'h0BAD_F00D);
    applyStimulus(1, 0, 32'h2000, 0);
    applyStimulus(1, 0, 32'h1100, 0);
    applyStimulus(1, 0, 32'h100, 0);
    applyStimulus(1, 0, 32'h102, 0);
    applyStimulus(1, 1, 32'h100, 32'h1234_5678);
    applyStimulus(1, 0, 32'h100, 0);
    applyStimulus(0, 0, 32'h100, 0);

    // Reset lands after two fill beats; the line must come back with a full refill.
    @(posedge clock);
    #1;
    address = 32'h300;
    memReadFlag = 1'b1;
    beatAddr.delete();
    beatWe.delete();
    beatData.delete();
    n = 0;
    while (beatAddr.size() < 2 && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("midFillBeats", beatAddr.size(), 2);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midFillResetMemReq", memReq, 1'b0);
    reset = 1'b0;
    memReadFlag = 1'b0;
    for (int i = 0; i < 16; i++) residentValid[i] = 1'b0;
    applyStimulus(1, 0, 32'h300, 0);
    applyStimulus(1, 0, 32'h100, 0);

    waitStates = 3;
    applyStimulus(1, 0, 32'h500, 0);
    applyStimulus(0, 1, 32'h504, 32'hCAFE_0001);
    applyStimulus(1, 0, 32'h504, 0);

    for (int t = 0; t < 150; t++) begin
      waitStates = $urandom_range(0, 2);
      a = 32'(tags[$urandom_range(0, 3)] * 256 + $urandom_range(0, 15) * 16
              + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      if (kind < 5) applyStimulus(1, 0, a, 0);
      else if (kind < 8) applyStimulus(0, 1, a, $urandom);
      else if (kind < 9) applyStimulus(1, 1, a, $urandom);
      else applyStimulus(0, 0, a, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
